// File: rtl/bit_serial_alu_seq_if.sv
// Operand/result bundle between the datapath and the bit-serial ALU sequencer.
// The master drives the request and operands; the slave returns status, result and flags.
interface bit_serial_alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, A, B, cntrl,
        input  busy, done, result, zero, negative, overflow, carry_out
    );

    modport slave (
        input  start, A, B, cntrl,
        output busy, done, result, zero, negative, overflow, carry_out
    );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Sequencer feeding a 1-bit ALU slice LSB-first over WIDTH cycles, then latching a
// WIDTH-bit result with zero/negative/overflow/carry flags.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; result and flags hold the last completion
//   S_RUN  | one operand bit per cycle through the slice, counter 0..WIDTH-1
module bit_serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    bit_serial_alu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [2:0]       op_q,       op_d;
    logic [WIDTH-1:0] a_sh_q,     a_sh_d;
    logic [WIDTH-1:0] b_sh_q,     b_sh_d;
    logic [WIDTH-1:0] work_q,     work_d;
    logic             carry_q,    carry_d;
    logic             cin_msb_q,  cin_msb_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             zero_q,     zero_d;
    logic             neg_q,      neg_d;
    logic             ovf_q,      ovf_d;
    logic             cout_q,     cout_d;
    logic             done_q,     done_d;

    logic             is_sub;
    logic             is_arith;
    logic             a_i;
    logic             b_i;
    logic             sum_i;
    logic             c_i;
    logic             bit_i;
    logic [WIDTH-1:0] work_next;

    // Bit slice: sub feeds ~b with the carry register preset to 1 at accept.
    always_comb begin
        is_sub   = (op_q == OP_SUB);
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        a_i      = a_sh_q[0];
        b_i      = b_sh_q[0] ^ is_sub;
        sum_i    = a_i ^ b_i ^ carry_q;
        c_i      = (a_i & b_i) | (carry_q & (a_i ^ b_i));
        case (op_q)
            OP_PASSB: bit_i = b_sh_q[0];
            OP_ADD,
            OP_SUB:   bit_i = sum_i;
            OP_AND:   bit_i = a_i & b_i;
            OP_OR:    bit_i = a_i | b_i;
            OP_XOR:   bit_i = a_i ^ b_i;
            default:  bit_i = 1'b0;
        endcase
        work_next = {bit_i, work_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        work_d    = work_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B;
                    op_d    = bus.cntrl;
                    carry_d = (bus.cntrl == OP_SUB);
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d  = work_next;
                carry_d = c_i;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_PENULT) begin
                    cin_msb_d = c_i;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    result_d = work_next;
                    zero_d   = (work_next == '0);
                    neg_d    = bit_i;
                    ovf_d    = is_arith & (cin_msb_q ^ c_i);
                    cout_d   = is_arith & c_i;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            work_q    <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            work_q    <= work_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq at WIDTH=8 and WIDTH=64: vector table, random ops,
// and hand sequences for busy-ignore, mid-op reset and back-to-back issue.
module tb_bit_serial_alu_seq;
    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        v;
        logic        c;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    logic clk = 1'b0;
    logic rst8;
    logic rst64;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t q8[$];
    exp_t q64[$];
    int   acc8[$];
    int   acc64[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_alu_seq_if #(.WIDTH(8))  bus8 ();
    bit_serial_alu_seq_if #(.WIDTH(64)) bus64 ();

    bit_serial_alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(bus8));
    bit_serial_alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(rst64), .bus(bus64));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Independent reference: wide integer math, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] bop;
        logic [64:0] full;
        m    = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a_in & m;
        b    = b_in & m;
        bop  = b;
        full = '0;
        e.res = '0; e.z = 1'b0; e.n = 1'b0; e.v = 1'b0; e.c = 1'b0;
        case (op)
            OP_PASSB: e.res = b;
            OP_ADD:   full = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                bop  = (~b) & m;
                full = {1'b0, a} + {1'b0, bop} + 65'd1;
            end
            OP_AND:   e.res = a & b;
            OP_OR:    e.res = a | b;
            OP_XOR:   e.res = a ^ b;
            default:  e.res = '0;
        endcase
        if (op == OP_ADD || op == OP_SUB) begin
            e.res = full[63:0] & m;
            e.c   = full[w];
            e.v   = (a[w-1] == bop[w-1]) && (e.res[w-1] != a[w-1]);
        end
        e.z = (e.res == '0);
        e.n = e.res[w-1];
        return e;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic z, input logic n,
                                input logic v, input logic c);
        vec_t t;
        t.op = op; t.a = a; t.b = b;
        t.e.res = {56'd0, r}; t.e.z = z; t.e.n = n; t.e.v = v; t.e.c = c;
        return t;
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        int   a;
        if (bus8.start && !bus8.busy && !rst8) acc8.push_back(cyc + 1);
        if (bus8.done) begin
            if (q8.size() == 0) begin
                check("w8 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                a = (acc8.size() != 0) ? acc8.pop_front() : -1000;
                check("w8 result",    bus8.result,    e.res);
                check("w8 zero",      bus8.zero,      e.z);
                check("w8 negative",  bus8.negative,  e.n);
                check("w8 overflow",  bus8.overflow,  e.v);
                check("w8 carry_out", bus8.carry_out, e.c);
                check("w8 latency",   64'(cyc - a),   64'd8);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        int   a;
        if (bus64.start && !bus64.busy && !rst64) acc64.push_back(cyc + 1);
        if (bus64.done) begin
            if (q64.size() == 0) begin
                check("w64 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                a = (acc64.size() != 0) ? acc64.pop_front() : -1000;
                check("w64 result",    bus64.result,    e.res);
                check("w64 zero",      bus64.zero,      e.z);
                check("w64 negative",  bus64.negative,  e.n);
                check("w64 overflow",  bus64.overflow,  e.v);
                check("w64 carry_out", bus64.carry_out, e.c);
                check("w64 latency",   64'(cyc - a),    64'd64);
            end
        end
    end

    task automatic wait_idle8();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (!bus8.busy) return;
        end
        check("w8 idle timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle64();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!bus64.busy) return;
        end
        check("w64 idle timeout", 64'd1, 64'd0);
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input exp_t e);
        wait_idle8();
        bus8.cntrl = op; bus8.A = a; bus8.B = b; bus8.start = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        wait_idle64();
        bus64.cntrl = op; bus64.A = a; bus64.B = b; bus64.start = 1'b1;
        q64.push_back(model(64, op, a, b));
        @(posedge clk); #1;
        bus64.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        logic [2:0]  op;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [63:0] wa;
        logic [63:0] wb;
        bit          seen;

        tbl[0]  = mk(OP_ADD,   8'h7F, 8'h01, 8'h80, 0, 1, 1, 0);
        tbl[1]  = mk(OP_SUB,   8'h05, 8'h05, 8'h00, 1, 0, 0, 1);
        tbl[2]  = mk(OP_SUB,   8'h00, 8'h01, 8'hFF, 0, 1, 0, 0);
        tbl[3]  = mk(OP_AND,   8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
        tbl[4]  = mk(OP_OR,    8'hF0, 8'h3C, 8'hFC, 0, 1, 0, 0);
        tbl[5]  = mk(OP_XOR,   8'hF0, 8'h3C, 8'hCC, 0, 1, 0, 0);
        tbl[6]  = mk(OP_PASSB, 8'hF0, 8'h3C, 8'h3C, 0, 0, 0, 0);
        tbl[7]  = mk(3'b001,   8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0);
        tbl[8]  = mk(3'b111,   8'hA5, 8'h5A, 8'h00, 1, 0, 0, 0);
        tbl[9]  = mk(OP_ADD,   8'hFF, 8'h01, 8'h00, 1, 0, 0, 1);
        tbl[10] = mk(OP_SUB,   8'h80, 8'h01, 8'h7F, 0, 0, 1, 1);
        tbl[11] = mk(OP_ADD,   8'h80, 8'h80, 8'h00, 1, 0, 1, 1);

        bus8.start = 1'b0;  bus8.A = '0;  bus8.B = '0;  bus8.cntrl = '0;
        bus64.start = 1'b0; bus64.A = '0; bus64.B = '0; bus64.cntrl = '0;
        rst8 = 1'b1; rst64 = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst8 = 1'b0; rst64 = 1'b0;
        @(negedge clk);
        check("w8 reset result", bus8.result, 64'd0);
        check("w8 reset status", {bus8.busy, bus8.done, bus8.zero, bus8.negative,
                                  bus8.overflow, bus8.carry_out}, 64'd0);
        check("w64 reset result", bus64.result, 64'd0);
        check("w64 reset status", {bus64.busy, bus64.done, bus64.zero, bus64.negative,
                                   bus64.overflow, bus64.carry_out}, 64'd0);

        for (int i = 0; i < 12; i++) issue8(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue8(op, ra, rb, model(8, op, {56'd0, ra}, {56'd0, rb}));
        end

        // start with new operands while busy must be ignored
        issue8(OP_ADD, 8'h12, 8'h34, model(8, OP_ADD, 64'h12, 64'h34));
        bus8.cntrl = OP_SUB; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("w8 busy held", bus8.busy, 64'd1);
        end
        @(posedge clk); #1;
        bus8.start = 1'b0;
        wait_idle8();
        check("w8 result held after ignore", bus8.result, 64'h46);

        // reset in the middle of an add
        issue8(OP_ADD, 8'h10, 8'h20, model(8, OP_ADD, 64'h10, 64'h20));
        wait_idle8();
        check("w8 pre-abort result", bus8.result, 64'h30);
        issue8(OP_ADD, 8'h55, 8'h0F, model(8, OP_ADD, 64'h55, 64'h0F));
        repeat (3) @(posedge clk);
        #1; rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        q8.delete();
        acc8.delete();
        @(negedge clk);
        check("w8 abort result", bus8.result, 64'd0);
        check("w8 abort status", {bus8.busy, bus8.done, bus8.zero, bus8.negative,
                                  bus8.overflow, bus8.carry_out}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("w8 no done after abort", bus8.done, 64'd0);
        end
        issue8(OP_ADD, 8'h03, 8'h04, model(8, OP_ADD, 64'h3, 64'h4));
        wait_idle8();
        check("w8 post-abort result", bus8.result, 64'h07);

        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            wa = {32'($urandom), 32'($urandom)};
            wb = {32'($urandom), 32'($urandom)};
            issue64(op, wa, wb);
        end

        // back-to-back: start held through the done cycle
        wait_idle64();
        bus64.cntrl = OP_ADD; bus64.A = {64{1'b1}}; bus64.B = 64'd1; bus64.start = 1'b1;
        q64.push_back(model(64, OP_ADD, {64{1'b1}}, 64'd1));
        @(posedge clk); #1;
        bus64.cntrl = OP_SUB; bus64.A = 64'h0123_4567_89AB_CDEF; bus64.B = 64'h1111_2222_3333_4444;
        q64.push_back(model(64, OP_SUB, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444));
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (bus64.done) seen = 1'b1;
        end
        if (!seen) check("w64 back-to-back done timeout", 64'd1, 64'd0);
        check("w64 b2b first zero", bus64.zero, 64'd1);
        check("w64 b2b first carry", bus64.carry_out, 64'd1);
        @(posedge clk); #1;
        check("w64 b2b second accepted", bus64.busy, 64'd1);
        bus64.start = 1'b0;
        wait_idle64();

        wait_idle8();
        repeat (2) @(negedge clk);
        check("w8 scoreboard drained", 64'(q8.size()), 64'd0);
        check("w64 scoreboard drained", 64'(q64.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
